// File: rtl/lab74_pkg.sv
// Shared definitions for the 74-series style lab library: shift modes and
// a width helper for counters sized to hold a value up to some maximum.
package lab74_pkg;

  // Mode select encoding, matching the 74HC194 S1:S0 pins.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Number of bits needed to represent values 0..v-1 (ceil(log2(v))).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_cnt_sat.sv
// Saturating shift counter with a one-cycle done pulse on the step that
// first reaches MAX. Loads clear the count and re-arm the pulse.
module shift_cnt_sat #(
  parameter int unsigned MAX = 8,
  parameter int unsigned CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rd,
  input  logic          ce,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          done
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX - 1);

  logic at_max;
  logic at_last;

  assign at_max  = (cnt == CNT_MAX);
  assign at_last = (cnt == CNT_LAST);

  // Count shifts up to MAX, pulse done only on the LAST->MAX transition.
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (!ce) begin
      done <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (inc) begin
      if (!at_max) begin
        cnt <= cnt + 1'b1;
      end
      done <= at_last;
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_reg_univ_n.sv
// N-bit universal shift register with 74HC194 mode semantics, clock
// enable, optional ring (rotate) mode and a saturating shift counter.
module shift_reg_univ_n
  import lab74_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          ROTATE = 1'b0,
  parameter int unsigned CW     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rd,
  input  logic             ce,
  input  logic [1:0]       s,
  input  logic             dsr,
  input  logic             dsl,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             sor,
  output logic             sol,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  mode_e            mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] q_nxt;
  logic             do_shift;
  logic             do_load;

  assign mode = mode_e'(s);

  // In ring mode the end bits wrap and the serial inputs are ignored.
  assign sin_r = ROTATE ? q[WIDTH-1] : dsr;
  assign sin_l = ROTATE ? q[0]       : dsl;

  // Decode the mode into the next register value and counter controls.
  always_comb begin
    q_nxt    = q;
    do_shift = 1'b0;
    do_load  = 1'b0;
    case (mode)
      MODE_SHR: begin
        q_nxt    = {q[WIDTH-2:0], sin_r};
        do_shift = 1'b1;
      end
      MODE_SHL: begin
        q_nxt    = {sin_l, q[WIDTH-1:1]};
        do_shift = 1'b1;
      end
      MODE_LOAD: begin
        q_nxt   = d;
        do_load = 1'b1;
      end
      default: begin
        q_nxt = q;
      end
    endcase
  end

  // Data register: async clear, updates only when enabled.
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      q <= '0;
    end else if (ce) begin
      q <= q_nxt;
    end
  end

  assign q_n = ~q;
  assign sor = q[WIDTH-1];
  assign sol = q[0];

  shift_cnt_sat #(
    .MAX (WIDTH),
    .CW  (CW)
  ) u_cnt (
    .clk  (clk),
    .rd   (rd),
    .ce   (ce),
    .clr  (do_load),
    .inc  (do_shift),
    .cnt  (cnt),
    .done (done)
  );

endmodule
